dual_issue_scheduler: RTL and testbench
=======================================

// Module: dual_issue_scheduler
// PURPOSE
// - In-order dual-issue scheduler between the two Instruction_decoder slots and the execute back-end.
// - Holds an 8-entry register scoreboard and decides each cycle whether slot0, slot0+slot1, or nothing issues.
// - Issue is blocked on RAW, WAW, intra-pair and structural (single memory port) hazards; writeback ports clear the scoreboard.
// PARAMETERS
// - NREG        8   architectural registers (R0..R7); R7 is the PC
// - CNT_W       16  width of the saturating stall counter
// - SINGLE_ISSUE 0  1 forces take[1]=0 (debug fallback)
// PORTS
// - clk         in   1      system clock, rising edge
// - rst_n       in   1      asynchronous active-low reset
// - s0_valid    in   1      slot0 holds a decoded instruction (s1_valid likewise for slot1, the younger)
// - sN_opcode   in   4      instruction[15:12] of slot N (N=0,1)
// - sN_src1     in   4      {used, reg} from the decoder src1
// - sN_src2     in   4      {used, reg} from the decoder src2
// - sN_dest     in   3      destination register
// - sN_wb       in   3      decoder WB field; bit2 = register write
// - sN_mem      in   2      decoder Memory field; 10 = load, 01 = store
// - issue_ready in   1      back-end accepts issue this cycle
// - flush       in   1      branch redirect; suppresses issue this cycle
// - wb0_valid   in   1      writeback port 0 retiring a write (wb1_valid likewise)
// - wbN_reg     in   3      register written by writeback port N
// - take        out  2      comb.; take[0]: slot0 consumed, take[1]: slot1 consumed
// - iss_valid   out  2      registered copy of take; slot fields are captured by the datapath on take
// - busy        out  8      scoreboard state; bit r = pending write to Rr
// - stall_cnt   out  CNT_W  cycles with s0_valid=1 and take[0]=0, saturating
// BEHAVIOUR
// - Reset: busy=0, iss_valid=00, stall_cnt=0; take is 00 while rst_n=0.
// - src_rdy(x) = !x[3] | !busy[x[2:0]]; writes(N) = sN_wb[2].
// - ctrl(N) = opcode in {1100 BEQ, 1000 JAL, 1001 JLR} or (writes(N) && sN_dest==7).
// - take[0] = s0_valid & issue_ready & !flush & src_rdy(s0_src1) & src_rdy(s0_src2)
//   & !(writes(0) & busy[s0_dest]).
// - take[1] = take[0] & s1_valid & !SINGLE_ISSUE & own src/WAW checks as slot0 & !ctrl(0)
//   & !(writes(0) & s1 src used & reg==s0_dest) & !(writes(0)&writes(1)&s0_dest==s1_dest)
//   & !(s0_mem!=0 & s1_mem!=0).
// - take[1] never asserts without take[0]; slot1 never issues alone.
// - Scoreboard next: busy[r] cleared by wbN_valid&wbN_reg==r; set by take[k]&writes(k)&dest==r; set wins.
// - Both wb ports on same reg: single clear; legal.
// - Latency: decision same cycle (combinational); iss_valid 1 cycle after take; busy updates on that edge.
// - stall_cnt: +1 when s0_valid&!take[0]; holds at 2^CNT_W-1; flush cycles count.
// - flush: take=00; busy unchanged (squashed writes are cleared by back-end via wb ports).
// - Reset mid-operation: all state returns to reset values asynchronously; no partial issue.
// - Undefined opcodes (decoder WB=000, Memory=00) issue as no-write, no-mem ops.
// CONFIGURATION
// - WB_BYPASS_EN defined: a register cleared by a wb port this cycle counts as not busy for src_rdy
//   and the WAW check (same-cycle wakeup).
// - WB_BYPASS_EN undefined: consumer waits one cycle after the writeback clear.
// STRUCTURE
// - Package iitb_sched_pkg: opcode constants (ADD, ADI, NAND, LHI, LW, SW, BEQ, JAL, JLR), WB_REGWR bit index,
//   MEM_LOAD/MEM_STORE encodings, PC_REG=3'd7, NREG.
// - Sub-module sched_scoreboard: busy vector, two clear ports, two set ports, set-over-clear priority.
// - Hazard/issue logic and stall counter stay in this module.
// TESTING
// - ADD R3,R1,R2 in s0 + ADD R5,R3,R4 in s1, busy=0 -> take=01, busy[3]=1 next cycle.
// - s0 LW R2, s1 SW -> take=01 (memory port); s0 LW, s1 NAND R6,R1,R1 -> take=11, busy[2]=1 and busy[6]=1.
// - busy[4]=1, s0 reads R4; wb0_valid with wb0_reg=4 -> take=01 same cycle only with WB_BYPASS_EN, else next cycle.
// - s0 JAL R7 / BEQ, s1 ADD -> take=01; s0 LHI R7 -> take=01.
// - s0 blocked 5 cycles then flush 1 cycle -> stall_cnt=6; saturation holds at 16'hFFFF.
// - rst_n low while busy=8'hFF, iss_valid=11 -> busy=0, iss_valid=00, take=00 immediately.

Source files
------------

// File: rtl/iitb_sched_pkg.sv
// iitb_sched_pkg: opcodes, decoder field encodings and helpers shared by the dual-issue scheduler
package iitb_sched_pkg;
    localparam int NREG = 8;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADI  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_LHI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0100;
    localparam logic [3:0] OP_SW   = 4'b0101;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JLR  = 4'b1001;
    localparam int WB_REGWR = 2;
    localparam logic [1:0] MEM_LOAD  = 2'b10;
    localparam logic [1:0] MEM_STORE = 2'b01;
    localparam logic [2:0] PC_REG = 3'd7;

    // src is {used, reg}; an unused operand is always ready
    function automatic logic src_rdy(input logic [3:0] src, input logic [NREG-1:0] busy);
        return !src[3] || !busy[src[2:0]];
    endfunction

    // control-flow ops (and any write to the PC) end the issue pair
    function automatic logic is_ctrl(input logic [3:0] op, input logic wr, input logic [2:0] dest);
        return op == OP_BEQ || op == OP_JAL || op == OP_JLR || (wr && dest == PC_REG);
    endfunction
endpackage

// File: rtl/sched_scoreboard.sv
// sched_scoreboard: pending-write bit per register, two clear ports, two set ports, set wins
// clk, rst_n      : clock, async active-low reset
// clr_en/clr_reg  : writeback clears (both ports may name the same register)
// set_en/set_reg  : issued writers marking their destination pending
// busy            : registered scoreboard state
module sched_scoreboard
    import iitb_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      clr_en,
    input  logic [1:0][2:0] clr_reg,
    input  logic [1:0]      set_en,
    input  logic [1:0][2:0] set_reg,
    output logic [NREG-1:0] busy
);
    logic [NREG-1:0] nxt;

    always_comb begin
        nxt = busy;
        for (int k = 0; k < 2; k++) if (clr_en[k]) nxt[clr_reg[k]] = 1'b0;
        for (int k = 0; k < 2; k++) if (set_en[k]) nxt[set_reg[k]] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else busy <= nxt;
endmodule

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler: in-order dual-issue hazard check, register scoreboard and stall counter
// inputs : clk, rst_n, s0_/s1_ {valid, opcode, src1, src2, dest, wb, mem}, issue_ready, flush,
//          wb0_/wb1_ {valid, reg}
// outputs: take (comb.), iss_valid (registered take), busy (scoreboard), stall_cnt (saturating)
// WB_BYPASS_EN: registers cleared by a writeback this cycle are treated as ready the same cycle
module dual_issue_scheduler
    import iitb_sched_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter bit SINGLE_ISSUE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s0_valid,
    input  logic [3:0]       s0_opcode,
    input  logic [3:0]       s0_src1,
    input  logic [3:0]       s0_src2,
    input  logic [2:0]       s0_dest,
    input  logic [2:0]       s0_wb,
    input  logic [1:0]       s0_mem,
    input  logic             s1_valid,
    input  logic [3:0]       s1_opcode,
    input  logic [3:0]       s1_src1,
    input  logic [3:0]       s1_src2,
    input  logic [2:0]       s1_dest,
    input  logic [2:0]       s1_wb,
    input  logic [1:0]       s1_mem,
    input  logic             issue_ready,
    input  logic             flush,
    input  logic             wb0_valid,
    input  logic [2:0]       wb0_reg,
    input  logic             wb1_valid,
    input  logic [2:0]       wb1_reg,
    output logic [1:0]       take,
    output logic [1:0]       iss_valid,
    output logic [NREG-1:0]  busy,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [NREG-1:0] eff;
    logic w0, w1, t0, t1, pair_raw, pair_waw, pair_mem;
    logic lint_unused;

`ifdef WB_BYPASS_EN
    logic [NREG-1:0] clr;

    always_comb begin
        clr = '0;
        if (wb0_valid) clr[wb0_reg] = 1'b1;
        if (wb1_valid) clr[wb1_reg] = 1'b1;
    end

    assign eff = busy & ~clr;
`else
    assign eff = busy;
`endif

    assign w0 = s0_wb[WB_REGWR];
    assign w1 = s1_wb[WB_REGWR];
    assign pair_raw = w0 && ((s1_src1[3] && s1_src1[2:0] == s0_dest) || (s1_src2[3] && s1_src2[2:0] == s0_dest));
    assign pair_waw = w0 && w1 && s0_dest == s1_dest;
    assign pair_mem = |s0_mem && |s1_mem;

    // rst_n gates take so nothing issues while reset is held
    assign t0 = rst_n && s0_valid && issue_ready && !flush
        && src_rdy(s0_src1, eff) && src_rdy(s0_src2, eff) && !(w0 && eff[s0_dest]);
    assign t1 = t0 && s1_valid && !SINGLE_ISSUE
        && src_rdy(s1_src1, eff) && src_rdy(s1_src2, eff) && !(w1 && eff[s1_dest])
        && !is_ctrl(s0_opcode, w0, s0_dest) && !pair_raw && !pair_waw && !pair_mem;
    assign take = {t1, t0};

    assign lint_unused = ^{s0_wb[1:0], s1_wb[1:0], s1_opcode};

    sched_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_en  ({wb1_valid, wb0_valid}),
        .clr_reg ({wb1_reg, wb0_reg}),
        .set_en  ({t1 && w1, t0 && w0}),
        .set_reg ({s1_dest, s0_dest}),
        .busy    (busy)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            iss_valid <= 2'b00;
            stall_cnt <= '0;
        end else begin
            iss_valid <= take;
            if (s0_valid && !t0 && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb_dual_issue_scheduler: scoreboard-queue bench for the dual-issue scheduler
module tb_dual_issue_scheduler;
    import iitb_sched_pkg::*;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] d;
        logic [2:0] wb;
        logic [1:0] mem;
    } slot_t;

    typedef struct {
        logic [1:0]  take;
        logic [7:0]  busy;
        logic [15:0] stall;
        logic [3:0]  sat;
    } exp_t;

    localparam logic [2:0] WR = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_ready, flush, wb0_valid, wb1_valid;
    logic [2:0]  wb0_reg, wb1_reg;
    slot_t       s0, s1;
    logic [1:0]  take, iss_valid, take_s, iss_s;
    logic [7:0]  busy, busy_s;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_s;

    exp_t        q[$];
    logic [7:0]  mbusy = '0;
    logic [15:0] mstall = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0.v), .s0_opcode(s0.op), .s0_src1(s0.a), .s0_src2(s0.b),
        .s0_dest(s0.d), .s0_wb(s0.wb), .s0_mem(s0.mem),
        .s1_valid(s1.v), .s1_opcode(s1.op), .s1_src1(s1.a), .s1_src2(s1.b),
        .s1_dest(s1.d), .s1_wb(s1.wb), .s1_mem(s1.mem),
        .issue_ready(issue_ready), .flush(flush),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb1_valid(wb1_valid), .wb1_reg(wb1_reg),
        .take(take), .iss_valid(iss_valid), .busy(busy), .stall_cnt(stall_cnt)
    );

    dual_issue_scheduler #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0.v), .s0_opcode(s0.op), .s0_src1(s0.a), .s0_src2(s0.b),
        .s0_dest(s0.d), .s0_wb(s0.wb), .s0_mem(s0.mem),
        .s1_valid(s1.v), .s1_opcode(s1.op), .s1_src1(s1.a), .s1_src2(s1.b),
        .s1_dest(s1.d), .s1_wb(s1.wb), .s1_mem(s1.mem),
        .issue_ready(issue_ready), .flush(flush),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb1_valid(wb1_valid), .wb1_reg(wb1_reg),
        .take(take_s), .iss_valid(iss_s), .busy(busy_s), .stall_cnt(stall_s)
    );

    function automatic logic [3:0] rs(input int n);
        logic [2:0] r;
        r = n[2:0];
        return {1'b1, r};
    endfunction

    function automatic slot_t ins(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] d, input logic [2:0] wb, input logic [1:0] mem);
        return {1'b1, op, a, b, d, wb, mem};
    endfunction

    task automatic idle();
        s0 = '0;
        s1 = '0;
        flush = 1'b0;
        issue_ready = 1'b1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        wb0_reg = '0;
        wb1_reg = '0;
    endtask

    // check take now, queue the model's post-edge state, then compare it after the edge
    task automatic step(input string name, input logic [1:0] et);
        exp_t e;
        logic [7:0] nb;
        #1;
        checks++;
        if (take !== et) begin
            errors++;
            $display("FAIL %s take: got %b expected %b", name, take, et);
        end
        nb = mbusy;
        if (wb0_valid) nb[wb0_reg] = 1'b0;
        if (wb1_valid) nb[wb1_reg] = 1'b0;
        if (et[0] && s0.wb[2]) nb[s0.d] = 1'b1;
        if (et[1] && s1.wb[2]) nb[s1.d] = 1'b1;
        if (s0.v && !et[0] && mstall != 16'hFFFF) mstall++;
        mbusy = nb;
        e.take = et;
        e.busy = nb;
        e.stall = mstall;
        e.sat = (mstall > 16'd15) ? 4'hF : mstall[3:0];
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        checks++;
        if (iss_valid !== e.take) begin
            errors++;
            $display("FAIL %s iss_valid: got %b expected %b", name, iss_valid, e.take);
        end
        checks++;
        if (busy !== e.busy) begin
            errors++;
            $display("FAIL %s busy: got %h expected %h", name, busy, e.busy);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, stall_cnt, e.stall);
        end
        checks++;
        if (stall_s !== e.sat) begin
            errors++;
            $display("FAIL %s stall_sat: got %0d expected %0d", name, stall_s, e.sat);
        end
    endtask

    task automatic clear(input string name, input logic [2:0] r0, input logic [2:0] r1);
        idle();
        wb0_valid = 1'b1;
        wb0_reg = r0;
        wb1_valid = 1'b1;
        wb1_reg = r1;
        step(name, 2'b00);
        idle();
    endtask

    task automatic test_reset();
        idle();
        s0 = ins(OP_ADD, rs(1), rs(2), 3'd3, WR, 2'b00);
        #1;
        checks++;
        if (take !== 2'b00 || busy !== 8'h00 || iss_valid !== 2'b00 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset: got take=%b busy=%h iss=%b stall=%0d expected 00/00/00/0",
                     take, busy, iss_valid, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_pairing();
        idle();
        s0 = ins(OP_ADD, rs(1), rs(2), 3'd3, WR, 2'b00);
        s1 = ins(OP_ADD, rs(3), rs(4), 3'd5, WR, 2'b00);
        step("raw_pair", 2'b01);
        checks++;
        if (busy !== 8'h08) begin
            errors++;
            $display("FAIL raw_pair_busy3: got %h expected 08", busy);
        end
        clear("raw_clear", 3'd3, 3'd3);
        s0 = ins(OP_ADD, rs(1), rs(2), 3'd1, WR, 2'b00);
        s1 = ins(OP_ADD, rs(3), rs(4), 3'd1, WR, 2'b00);
        step("waw_pair", 2'b01);
        clear("waw_clear", 3'd1, 3'd1);
        s0 = ins(OP_ADD, rs(3), rs(4), 3'd1, WR, 2'b00);
        s1 = ins(OP_ADI, rs(5), 4'h0, 3'd2, WR, 2'b00);
        step("indep_pair", 2'b11);
        clear("indep_clear", 3'd1, 3'd2);
        s1 = ins(OP_ADD, rs(3), rs(4), 3'd5, WR, 2'b00);
        step("slot1_alone", 2'b00);
        idle();
        s0 = ins(OP_ADD, rs(1), rs(2), 3'd3, WR, 2'b00);
        issue_ready = 1'b0;
        step("not_ready", 2'b00);
        idle();
    endtask

    task automatic test_memory();
        idle();
        s0 = ins(OP_LW, rs(1), 4'h0, 3'd2, WR, MEM_LOAD);
        s1 = ins(OP_SW, rs(3), rs(4), 3'd0, 3'b000, MEM_STORE);
        step("lw_sw", 2'b01);
        clear("lw_clear", 3'd2, 3'd2);
        s0 = ins(OP_LW, rs(1), 4'h0, 3'd2, WR, MEM_LOAD);
        s1 = ins(OP_NAND, rs(1), rs(1), 3'd6, WR, 2'b00);
        step("lw_nand", 2'b11);
        checks++;
        if (busy !== 8'h44) begin
            errors++;
            $display("FAIL lw_nand_busy: got %h expected 44", busy);
        end
        clear("lw_nand_clear", 3'd2, 3'd6);
    endtask

    task automatic test_bypass();
        idle();
        s0 = ins(OP_ADD, 4'h0, 4'h0, 3'd4, WR, 2'b00);
        step("bp_setup", 2'b01);
        s0 = ins(OP_ADD, rs(4), rs(1), 3'd5, WR, 2'b00);
        wb0_valid = 1'b1;
        wb0_reg = 3'd4;
`ifdef WB_BYPASS_EN
        step("bp_same_cycle", 2'b01);
`else
        step("bp_same_cycle", 2'b00);
        wb0_valid = 1'b0;
        step("bp_next_cycle", 2'b01);
`endif
        clear("bp_clear", 3'd5, 3'd5);
    endtask

    task automatic test_ctrl();
        idle();
        s0 = ins(OP_JAL, 4'h0, 4'h0, PC_REG, WR, 2'b00);
        s1 = ins(OP_ADD, rs(2), rs(3), 3'd1, WR, 2'b00);
        step("jal", 2'b01);
        clear("jal_clear", 3'd7, 3'd7);
        s0 = ins(OP_BEQ, rs(1), rs(2), 3'd0, 3'b000, 2'b00);
        s1 = ins(OP_ADD, rs(2), rs(3), 3'd1, WR, 2'b00);
        step("beq", 2'b01);
        s0 = ins(OP_LHI, 4'h0, 4'h0, PC_REG, WR, 2'b00);
        s1 = ins(OP_ADD, rs(2), rs(3), 3'd1, WR, 2'b00);
        step("lhi_r7", 2'b01);
        clear("lhi_clear", 3'd7, 3'd7);
        s0 = ins(4'b1111, 4'h0, 4'h0, 3'd3, 3'b000, 2'b00);
        s1 = ins(OP_ADD, rs(2), rs(3), 3'd1, WR, 2'b00);
        step("undef_op", 2'b11);
        clear("undef_clear", 3'd1, 3'd1);
    endtask

    task automatic test_stall();
        logic [15:0] base;
        idle();
        s0 = ins(OP_ADD, 4'h0, 4'h0, 3'd4, WR, 2'b00);
        step("stall_setup", 2'b01);
        base = mstall;
        s0 = ins(OP_ADD, rs(4), rs(1), 3'd5, WR, 2'b00);
        for (int i = 0; i < 5; i++) step("stall_blocked", 2'b00);
        flush = 1'b1;
        step("stall_flush", 2'b00);
        checks++;
        if (stall_cnt !== base + 16'd6) begin
            errors++;
            $display("FAIL stall_six: got %0d expected %0d", stall_cnt, base + 16'd6);
        end
        flush = 1'b0;
        for (int i = 0; i < 12; i++) step("stall_saturate", 2'b00);
        checks++;
        if (stall_s !== 4'hF) begin
            errors++;
            $display("FAIL stall_sat_hold: got %0d expected 15", stall_s);
        end
        clear("stall_clear", 3'd4, 3'd4);
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 8; i += 2) begin
            s0 = ins(OP_ADD, 4'h0, 4'h0, 3'(i), WR, 2'b00);
            s1 = ins(OP_ADD, 4'h0, 4'h0, 3'(i + 1), WR, 2'b00);
            step("fill_pair", 2'b11);
        end
        checks++;
        if (busy !== 8'hFF || iss_valid !== 2'b11) begin
            errors++;
            $display("FAIL fill_state: got busy=%h iss=%b expected FF/11", busy, iss_valid);
        end
        s0 = ins(OP_ADD, 4'h0, 4'h0, 3'd0, WR, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (take !== 2'b00 || busy !== 8'h00 || iss_valid !== 2'b00 || stall_cnt !== 16'd0 || stall_s !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got take=%b busy=%h iss=%b stall=%0d expected 00/00/00/0",
                     take, busy, iss_valid, stall_cnt);
        end
        mbusy = '0;
        mstall = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        s0 = ins(OP_ADD, rs(1), 4'h0, 3'd2, WR, 2'b00);
        step("after_reset", 2'b01);
        clear("after_reset_clear", 3'd2, 3'd2);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        test_reset();
        test_pairing();
        test_memory();
        test_bypass();
        test_ctrl();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
